branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 94 +++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: address type, default BHT size
// and the 2-bit counter state encodings.
`ifndef BRANCH_PREDICTOR_CONSTANTS
`define BRANCH_PREDICTOR_CONSTANTS
`define ADDR_TYPE [31:0]
`define BHT_ENTRY_BITS 8
`endif

package branch_predictor_pkg;

  localparam int ADDR_W = 32;

  // Saturating counter states; the MSB is the taken prediction.
  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Step one state toward the observed outcome, saturating at both ends.
  always_comb begin
    nxt = cur;
    case (cur)
      CNT_STRONG_NT: nxt = taken ? CNT_WEAK_NT  : CNT_STRONG_NT;
      CNT_WEAK_NT:   nxt = taken ? CNT_WEAK_T   : CNT_STRONG_NT;
      CNT_WEAK_T:    nxt = taken ? CNT_STRONG_T : CNT_WEAK_NT;
      CNT_STRONG_T:  nxt = taken ? CNT_STRONG_T : CNT_WEAK_T;
      default:       nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word address, looked up by the fetcher and trained only at ROB commit.
// Optional build macro PREDICTOR_GSHARE_EN XORs a global outcome history
// into the index (gshare) for both lookup and update.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = `BHT_ENTRY_BITS,
  parameter int HIST_BITS  = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             enable_from_fetcher,
  input  logic `ADDR_TYPE  inst_pos_from_fetcher,
  output logic             valid_to_fetcher,
  output logic             predict_jump_to_fetcher,
  input  logic             enable_from_rob,
  input  logic             jump_result_from_rob,
  input  logic `ADDR_TYPE  inst_pos_from_rob
);

  localparam int ENTRIES = 1 << ENTRY_BITS;

  logic [1:0]            bht [ENTRIES];
  logic [ENTRY_BITS-1:0] fetch_idx;
  logic [ENTRY_BITS-1:0] rob_idx;
  logic [1:0]            rob_cnt;
  logic [1:0]            rob_cnt_nxt;
  logic                  upd_fire;

  // Byte offset and bits above the index never influence the prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{inst_pos_from_fetcher[ADDR_W-1:ENTRY_BITS+2],
                            inst_pos_from_fetcher[1:0],
                            inst_pos_from_rob[ADDR_W-1:ENTRY_BITS+2],
                            inst_pos_from_rob[1:0]};

  assign upd_fire = rdy_in && enable_from_rob;

`ifdef PREDICTOR_GSHARE_EN
  logic [HIST_BITS-1:0]  hist;
  logic [ENTRY_BITS-1:0] hist_ext;

  // Zero-extend (or truncate) the history to index width.
  always_comb begin
    hist_ext = '0;
    for (int i = 0; i < HIST_BITS && i < ENTRY_BITS; i++) hist_ext[i] = hist[i];
  end

  assign fetch_idx = inst_pos_from_fetcher[ENTRY_BITS+1:2] ^ hist_ext;
  assign rob_idx   = inst_pos_from_rob[ENTRY_BITS+1:2] ^ hist_ext;

  // Shift each committed outcome into the history LSB.
  always_ff @(posedge clk_in) begin
    if (rst_in)        hist <= '0;
    else if (upd_fire) hist <= {hist[HIST_BITS-2:0], jump_result_from_rob};
  end
`else
  localparam int unused_hist_bits = HIST_BITS;

  assign fetch_idx = inst_pos_from_fetcher[ENTRY_BITS+1:2];
  assign rob_idx   = inst_pos_from_rob[ENTRY_BITS+1:2];
`endif

  assign rob_cnt = bht[rob_idx];

  sat_counter2 u_sat_counter2 (
    .cur   (rob_cnt),
    .taken (jump_result_from_rob),
    .nxt   (rob_cnt_nxt)
  );

  // Counter table: reset to weak-not-taken, trained only by ROB commits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= CNT_WEAK_NT;
    end else if (upd_fire) begin
      bht[rob_idx] <= rob_cnt_nxt;
    end
  end

  // Registered lookup; reads the table before any same-edge update lands.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_to_fetcher        <= 1'b0;
      predict_jump_to_fetcher <= 1'b0;
    end else if (rdy_in) begin
      valid_to_fetcher <= enable_from_fetcher;
      if (enable_from_fetcher) predict_jump_to_fetcher <= bht[fetch_idx][1];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, compared against a table-of-integers reference model.
module tb_branch_predictor;

  localparam int EB   = 8;
  localparam int HB   = 8;
  localparam int NENT = 1 << EB;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        enable_from_fetcher = 1'b0;
  logic [31:0] inst_pos_from_fetcher = '0;
  logic        valid_to_fetcher;
  logic        predict_jump_to_fetcher;
  logic        enable_from_rob = 1'b0;
  logic        jump_result_from_rob = 1'b0;
  logic [31:0] inst_pos_from_rob = '0;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int cnt [NENT];
  int hist = 0;
  int exp_valid = 0;
  int exp_pred  = 0;

  branch_predictor #(.ENTRY_BITS(EB), .HIST_BITS(HB)) dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .rdy_in                  (rdy_in),
    .enable_from_fetcher     (enable_from_fetcher),
    .inst_pos_from_fetcher   (inst_pos_from_fetcher),
    .valid_to_fetcher        (valid_to_fetcher),
    .predict_jump_to_fetcher (predict_jump_to_fetcher),
    .enable_from_rob         (enable_from_rob),
    .jump_result_from_rob    (jump_result_from_rob),
    .inst_pos_from_rob       (inst_pos_from_rob)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_idx(input logic [31:0] pc);
    int i;
    i = (pc / 4) % NENT;
`ifdef PREDICTOR_GSHARE_EN
    i = i ^ (hist % NENT);
`endif
    return i;
  endfunction

  // One clock cycle: apply inputs, advance the model, then check outputs.
  task automatic cycle(input string tag, input bit rst, input bit rdy,
                       input bit fe, input logic [31:0] fpc,
                       input bit re, input bit res, input logic [31:0] rpc);
    int fi, ri;
    rst_in = rst; rdy_in = rdy;
    enable_from_fetcher = fe; inst_pos_from_fetcher = fpc;
    enable_from_rob = re; jump_result_from_rob = res; inst_pos_from_rob = rpc;
    if (rst) begin
      for (int i = 0; i < NENT; i++) cnt[i] = 1;
      hist = 0; exp_valid = 0; exp_pred = 0;
    end else if (rdy) begin
      fi = model_idx(fpc);
      ri = model_idx(rpc);
      exp_valid = fe ? 1 : 0;
      if (fe) exp_pred = (cnt[fi] >= 2) ? 1 : 0;
      if (re) begin
        if (res) cnt[ri] = (cnt[ri] == 3) ? 3 : cnt[ri] + 1;
        else     cnt[ri] = (cnt[ri] == 0) ? 0 : cnt[ri] - 1;
        hist = ((hist * 2) + (res ? 1 : 0)) % (1 << HB);
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    check({tag, ".valid"}, int'(valid_to_fetcher), exp_valid);
    check({tag, ".pred"}, int'(predict_jump_to_fetcher), exp_pred);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input bit res);
    cycle(tag, 0, 1, 0, 32'h0, 1, res, pc);
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    cycle(tag, 0, 1, 1, pc, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] fpc, rpc;
    for (int i = 0; i < NENT; i++) cnt[i] = 0;

    // Reset state, then lookup at 0x1000 sees weak-not-taken
    cycle("reset", 1, 1, 1, 32'h1000, 1, 1, 32'h1000);
    cycle("idle", 0, 1, 0, 32'h0, 0, 0, 32'h0);
    look("lk1000_init", 32'h1000);
    check("lk1000_init.direct", int'(predict_jump_to_fetcher), 0);

    // Two taken -> 11, third taken stays 11, one not-taken -> 10
    upd("t1_1000", 32'h1000, 1);
    upd("t2_1000", 32'h1000, 1);
    look("lk1000_t2", 32'h1000);
    check("lk1000_t2.direct", int'(predict_jump_to_fetcher), 1);
    upd("t3_1000", 32'h1000, 1);
    upd("nt_1000", 32'h1000, 0);
    look("lk1000_10", 32'h1000);
    upd("nt2_1000", 32'h1000, 0);
    look("lk1000_01", 32'h1000);
    check("lk1000_01.direct", int'(predict_jump_to_fetcher), 0);

    // Saturate at 00 then one taken -> 01, predicts not-taken
    for (int k = 0; k < 5; k++) upd("nt_2004", 32'h2004, 0);
    upd("t_2004", 32'h2004, 1);
    look("lk2004", 32'h2007);
    check("lk2004.direct", int'(predict_jump_to_fetcher), 0);
    upd("t2_2004", 32'h2004, 1);
    look("lk2004_10", 32'h2004);

    // Same-cycle lookup and taken update on 0x3008 (counter 01 -> 10)
    upd("nt_3008", 32'h3008, 1);
    upd("nt_3008b", 32'h3008, 0);
    cycle("rbw_3008", 0, 1, 1, 32'h3008, 1, 1, 32'h3008);
    check("rbw_3008.direct", int'(predict_jump_to_fetcher), 0);
    look("lk3008", 32'h3008);
    check("lk3008.direct", int'(predict_jump_to_fetcher), 1);

    // rdy low: requests ignored, outputs and counters frozen
    cycle("rdy0_a", 0, 0, 1, 32'h1000, 1, 1, 32'h1000);
    check("rdy0_a.valid_hold", int'(valid_to_fetcher), 1);
    cycle("rdy0_b", 0, 0, 1, 32'h1000, 1, 1, 32'h1000);
    look("lk1000_after_rdy0", 32'h1000);
    cycle("rdy0_c", 0, 1, 0, 32'h0, 0, 0, 32'h0);
    cycle("rdy0_d", 0, 0, 1, 32'h3008, 0, 0, 32'h0);

    // Reset mid-sequence, with a lookup in flight and rdy low
    look("pre_rst", 32'h3008);
    cycle("rst_mid", 1, 0, 1, 32'h3008, 1, 1, 32'h3008);
    check("rst_mid.valid_direct", int'(valid_to_fetcher), 0);
    look("lk3008_post_rst", 32'h3008);
    look("lk2004_post_rst", 32'h2004);

    // History-sensitive sequence: two taken at PC 0, then lookup PC 0
    cycle("rst_h", 1, 1, 0, 32'h0, 0, 0, 32'h0);
    upd("h_t1", 32'h0, 1);
    upd("h_t2", 32'h0, 1);
    look("h_lk0", 32'h0);
`ifdef PREDICTOR_GSHARE_EN
    check("h_lk0.gshare_idx3", int'(predict_jump_to_fetcher), 0);
`else
    check("h_lk0.plain_idx0", int'(predict_jump_to_fetcher), 1);
`endif

    // Randomized traffic over a small set of indices to force collisions
    for (int n = 0; n < 3000; n++) begin
      fpc = $urandom;
      rpc = $urandom;
      fpc[EB+1:2] = EB'($urandom_range(0, 7));
      rpc[EB+1:2] = ($urandom_range(0, 3) == 0) ? fpc[EB+1:2]
                                                : EB'($urandom_range(0, 7));
      cycle("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            1'($urandom), fpc, 1'($urandom), 1'($urandom), rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
